spi_slave_io: RTL and testbench

//  SPI slave (mode 0, CPOL=0/CPHA=0) peripheral on the light8080 I/O bus; counterpart of the SoC's SPI master.

---
 rtl/spi_slave_io_pkg.sv | 33 +++
 rtl/spi_slave_io_sync.sv | 31 +++
 rtl/spi_slave_io.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_io.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_io_pkg.sv
// ============================================================================
// spi_slave_io_pkg : register map, bit positions and FSM states of spi_slave_io
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_slave_io_pkg;

   // Register offsets from BASE_ADDR
   localparam logic [7:0] OFS_DATA = 8'd0;
   localparam logic [7:0] OFS_STAT = 8'd1;
   localparam logic [7:0] OFS_CTRL = 8'd2;

   // STAT bit positions
   localparam int STAT_TXEMPTY = 0;
   localparam int STAT_RXFULL  = 1;
   localparam int STAT_SSACT   = 2;
   localparam int STAT_OVR     = 3;

   // CTRL bit positions (present only with SPI_SLAVE_IRQ_EN)
   localparam int CTRL_IE_RX  = 0;
   localparam int CTRL_IE_TX  = 1;
   localparam int CTRL_IE_OVR = 2;

   typedef enum logic [1:0] {
      ST_WAIT_IDLE = 2'd0,
      ST_IDLE      = 2'd1,
      ST_SHIFT     = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_slave_io_sync.sv
// ============================================================================
// spi_slave_io_sync : 2-flop synchronizer plus edge-detect flop (rise/fall pulses)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_io_sync #(
   parameter logic RESET_VAL = 1'b0
)(
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) sr <= {3{RESET_VAL}};
      else       sr <= {sr[1:0], din};
   end

   assign level = sr[1];
   assign rise  = sr[1] & ~sr[2];
   assign fall  = ~sr[1] & sr[2];

endmodule

`default_nettype wire

// File: rtl/spi_slave_io.sv
// ============================================================================
// spi_slave_io : SPI mode-0 slave on the light8080 I/O bus (DATA/STAT/CTRL).
// Optional interrupt logic and CTRL register: macro SPI_SLAVE_IRQ_EN.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_io
   import spi_slave_io_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'h90,
   parameter bit         MSB_FIRST = 1'b1,
   parameter logic [7:0] TX_FILL   = 8'hFF
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       io_sel,
   input  logic       io_rd,
   input  logic       io_wr,
   input  logic [7:0] io_addr,
   input  logic [7:0] io_din,
   output logic [7:0] io_dout,
   input  logic       spi_sck,
   input  logic       spi_ss_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   output logic       irq
);

   localparam logic [7:0] ADDR_DATA = BASE_ADDR + OFS_DATA;
   localparam logic [7:0] ADDR_STAT = BASE_ADDR + OFS_STAT;
   localparam logic [7:0] ADDR_CTRL = BASE_ADDR + OFS_CTRL;

   logic sck_level, sck_rise, sck_fall;
   logic ss_level, ss_rise, ss_fall;
   logic [1:0] mosi_sync;
   logic unused_sck_level;

   state_t state, next_state;
   logic start, rx_done, sample, advance, load;
   logic [2:0] bitcnt;
   logic [7:0] rx_shift, rx_next, rx_data;
   logic [7:0] tx_shift, tx_hold, load_val;
   logic rxfull, txfull, ovr;
   logic sel_data, sel_stat, sel_ctrl, data_rd, data_wr, stat_wr;
   logic [7:0] status, ctrl_val, rd_val;

   spi_slave_io_sync #(.RESET_VAL(1'b0)) u_sync_sck (
      .clock (clock), .reset (reset), .din (spi_sck),
      .level (sck_level), .rise (sck_rise), .fall (sck_fall)
   );

   // ss_n chain resets low so WAIT_IDLE only exits on a genuinely deselected bus
   spi_slave_io_sync #(.RESET_VAL(1'b0)) u_sync_ss (
      .clock (clock), .reset (reset), .din (spi_ss_n),
      .level (ss_level), .rise (ss_rise), .fall (ss_fall)
   );

   assign unused_sck_level = sck_level;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) mosi_sync <= 2'b00;
      else       mosi_sync <= {mosi_sync[0], spi_mosi};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_WAIT_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      start      = 1'b0;
      rx_done    = 1'b0;
      sample     = 1'b0;
      advance    = 1'b0;
      case (state)
         ST_WAIT_IDLE: if (ss_level) next_state = ST_IDLE;
         ST_IDLE: begin
            if (ss_fall) begin
               start      = 1'b1;
               next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ss_rise) begin
               next_state = ST_IDLE;
            end else begin
               sample  = sck_rise;
               rx_done = sck_rise && (bitcnt == 3'd7);
               // The fall right after a reload must keep the freshly loaded first bit
               advance = sck_fall && (bitcnt != 3'd0);
            end
         end
         default: next_state = ST_WAIT_IDLE;
      endcase
   end

   assign load     = start | rx_done;
   assign load_val = txfull ? tx_hold : TX_FILL;
   assign rx_next  = MSB_FIRST ? {rx_shift[6:0], mosi_sync[1]} : {mosi_sync[1], rx_shift[7:1]};

   assign sel_data = io_sel && (io_addr == ADDR_DATA);
   assign sel_stat = io_sel && (io_addr == ADDR_STAT);
   assign sel_ctrl = io_sel && (io_addr == ADDR_CTRL);
   assign data_rd  = sel_data && io_rd;
   assign data_wr  = sel_data && io_wr;
   assign stat_wr  = sel_stat && io_wr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bitcnt      <= 3'd0;
         rx_shift    <= 8'h00;
         tx_shift    <= 8'h00;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
      end else begin
         spi_miso_oe <= (next_state == ST_SHIFT);
         if (start)       bitcnt <= 3'd0;
         else if (sample) bitcnt <= bitcnt + 3'd1;
         if (sample) rx_shift <= rx_next;
         if (load) begin
            tx_shift <= load_val;
            spi_miso <= MSB_FIRST ? load_val[7] : load_val[0];
         end else if (advance) begin
            tx_shift <= MSB_FIRST ? {tx_shift[6:0], 1'b0} : {1'b0, tx_shift[7:1]};
            spi_miso <= MSB_FIRST ? tx_shift[6] : tx_shift[1];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_data <= 8'h00;
         rxfull  <= 1'b0;
         ovr     <= 1'b0;
         tx_hold <= 8'h00;
         txfull  <= 1'b0;
      end else begin
         // A completing byte beats a concurrent DATA read
         if (rx_done) begin
            if (!rxfull || data_rd) begin
               rx_data <= rx_next;
               rxfull  <= 1'b1;
            end
         end else if (data_rd) begin
            rxfull <= 1'b0;
         end
         if (rx_done && rxfull && !data_rd)    ovr <= 1'b1;
         else if (stat_wr && io_din[STAT_OVR]) ovr <= 1'b0;
         if (data_wr) begin
            tx_hold <= io_din;
            txfull  <= 1'b1;
         end else if (load) begin
            txfull  <= 1'b0;
         end
      end
   end

   always_comb begin
      status               = 8'h00;
      status[STAT_TXEMPTY] = ~txfull;
      status[STAT_RXFULL]  = rxfull;
      status[STAT_SSACT]   = ~ss_level;
      status[STAT_OVR]     = ovr;
   end

`ifdef SPI_SLAVE_IRQ_EN
   logic [2:0] ie;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ie  <= 3'b000;
         irq <= 1'b0;
      end else begin
         if (sel_ctrl && io_wr) ie <= io_din[2:0];
         irq <= (ie[CTRL_IE_RX] & rxfull) | (ie[CTRL_IE_TX] & ~txfull) | (ie[CTRL_IE_OVR] & ovr);
      end
   end

   assign ctrl_val = {5'b00000, ie};
`else
   assign ctrl_val = 8'h00;
   assign irq      = 1'b0;
`endif

   always_comb begin
      rd_val = 8'h00;
      if (sel_data)      rd_val = rx_data;
      else if (sel_stat) rd_val = status;
      else if (sel_ctrl) rd_val = ctrl_val;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                        io_dout <= 8'h00;
      else if (io_rd && (sel_data || sel_stat || sel_ctrl)) io_dout <= rd_val;
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_io.sv
// ============================================================================
// tb_spi_slave_io : directed and randomized bench for spi_slave_io (mode 0, MSB first)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_io;

   localparam logic [7:0] BASE  = 8'h90;
   localparam logic [7:0] RDATA = BASE;
   localparam logic [7:0] RSTAT = BASE + 8'd1;
   localparam logic [7:0] RCTRL = BASE + 8'd2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       io_sel = 1'b0, io_rd = 1'b0, io_wr = 1'b0;
   logic [7:0] io_addr = 8'h00, io_din = 8'h00;
   logic [7:0] io_dout;
   logic       spi_sck = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
   logic       spi_miso, spi_miso_oe, irq;

   int compared   = 0;
   int mismatched = 0;

   spi_slave_io dut (
      .clock (clock), .reset (reset),
      .io_sel (io_sel), .io_rd (io_rd), .io_wr (io_wr),
      .io_addr (io_addr), .io_din (io_din), .io_dout (io_dout),
      .spi_sck (spi_sck), .spi_ss_n (spi_ss_n), .spi_mosi (spi_mosi),
      .spi_miso (spi_miso), .spi_miso_oe (spi_miso_oe), .irq (irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock);
   endtask

   task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
      io_sel = 1'b1; io_rd = 1'b1; io_addr = a;
      tick();
      io_sel = 1'b0; io_rd = 1'b0;
      d = io_dout;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      io_sel = 1'b1; io_wr = 1'b1; io_addr = a; io_din = d;
      tick();
      io_sel = 1'b0; io_wr = 1'b0;
   endtask

   // One master byte, sck = clock/8; optionally a DATA read lands on the cycle the 8th rise is seen
   task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit rd_last,
                           output logic [7:0] rx, output logic [7:0] rd_val);
      rx = 8'h00;
      rd_val = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = tx[7-i];
         tick(4);
         rx[7-i] = spi_miso;
         spi_sck = 1'b1;
         if (rd_last && i == 7) begin
            tick(2);
            io_sel = 1'b1; io_rd = 1'b1; io_addr = RDATA;
            tick(1);
            io_sel = 1'b0; io_rd = 1'b0;
            rd_val = io_dout;
            tick(1);
         end else begin
            tick(4);
         end
         spi_sck = 1'b0;
      end
   endtask

   task automatic frame_end();
      tick(4);
      spi_ss_n = 1'b1;
      tick(6);
   endtask

   initial begin
      logic [7:0] d, got, rdv;
      logic [7:0] m_hold, m_rxdata, r, exp_miso;
      logic       m_txfull, m_rxfull, m_ovr;
      int         n;

      // Reset state
      tick(3);
      reset = 1'b0;
      tick(4);
      check("rst_dout", io_dout, 8'h00);
      check("rst_miso", {7'b0, spi_miso}, 8'h00);
      check("rst_oe",   {7'b0, spi_miso_oe}, 8'h00);
      check("rst_irq",  {7'b0, irq}, 8'h00);
      cpu_read(RSTAT, d); check("rst_stat", d, 8'h01);
      cpu_read(RCTRL, d); check("rst_ctrl", d, 8'h00);

      // 1: CPU queues A5, master sends 3C
      cpu_write(RDATA, 8'hA5);
      cpu_read(RSTAT, d); check("t1_stat_txfull", d, 8'h00);
      spi_ss_n = 1'b0;
      tick(1);
      spi_byte(8'h3C, 8, 1'b0, got, rdv);
      check("t1_oe_active", {7'b0, spi_miso_oe}, 8'h01);
      check("t1_miso", got, 8'hA5);
      frame_end();
      check("t1_oe_idle", {7'b0, spi_miso_oe}, 8'h00);
      cpu_read(RSTAT, d); check("t1_stat", d, 8'h03);
      cpu_read(RDATA, d); check("t1_data", d, 8'h3C);
      cpu_read(RSTAT, d); check("t1_stat_after", d, 8'h01);

      // 2: no CPU byte -> fill pattern
      spi_ss_n = 1'b0;
      spi_byte(8'h55, 8, 1'b0, got, rdv);
      check("t2_miso", got, 8'hFF);
      frame_end();
      cpu_read(RSTAT, d); check("t2_stat", d, 8'h03);
      cpu_read(RDATA, d); check("t2_data", d, 8'h55);

      // 3: overrun
      spi_ss_n = 1'b0;
      spi_byte(8'h11, 8, 1'b0, got, rdv);
      frame_end();
      spi_ss_n = 1'b0;
      spi_byte(8'h22, 8, 1'b0, got, rdv);
      frame_end();
      cpu_read(RSTAT, d); check("t3_stat_ovr", d, 8'h0B);
      cpu_read(RDATA, d); check("t3_data", d, 8'h11);
      cpu_write(RSTAT, 8'h08);
      cpu_read(RSTAT, d); check("t3_stat_clr", d, 8'h01);

      // 4: aborted partial byte then full byte
      spi_ss_n = 1'b0;
      spi_byte(8'hF0, 5, 1'b0, got, rdv);
      frame_end();
      check("t4_oe_low", {7'b0, spi_miso_oe}, 8'h00);
      cpu_read(RSTAT, d); check("t4_stat_partial", d, 8'h01);
      spi_ss_n = 1'b0;
      spi_byte(8'h0F, 8, 1'b0, got, rdv);
      frame_end();
      cpu_read(RSTAT, d); check("t4_stat", d, 8'h03);
      cpu_read(RDATA, d); check("t4_data", d, 8'h0F);
      cpu_read(RSTAT, d); check("t4_stat_after", d, 8'h01);

      // 5: DATA read in the completion cycle with rxfull already set
      spi_ss_n = 1'b0;
      spi_byte(8'h5A, 8, 1'b0, got, rdv);
      frame_end();
      spi_ss_n = 1'b0;
      spi_byte(8'h77, 8, 1'b1, got, rdv);
      check("t5_concurrent_read", rdv, 8'h5A);
      frame_end();
      cpu_read(RSTAT, d); check("t5_stat", d, 8'h03);
      cpu_read(RDATA, d); check("t5_data", d, 8'h77);

      // 6: interrupt
`ifdef SPI_SLAVE_IRQ_EN
      cpu_write(RCTRL, 8'h01);
      cpu_read(RCTRL, d); check("t6_ctrl", d, 8'h01);
      tick(2);
      check("t6_irq_idle", {7'b0, irq}, 8'h00);
      spi_ss_n = 1'b0;
      spi_byte(8'h96, 8, 1'b0, got, rdv);
      frame_end();
      check("t6_irq_set", {7'b0, irq}, 8'h01);
      cpu_read(RDATA, d); check("t6_data", d, 8'h96);
      tick(2);
      check("t6_irq_clr", {7'b0, irq}, 8'h00);
      cpu_write(RCTRL, 8'h00);
`else
      cpu_write(RCTRL, 8'h07);
      cpu_read(RCTRL, d); check("t6_ctrl", d, 8'h00);
      spi_ss_n = 1'b0;
      spi_byte(8'h96, 8, 1'b0, got, rdv);
      frame_end();
      check("t6_irq_off", {7'b0, irq}, 8'h00);
      cpu_read(RDATA, d); check("t6_data", d, 8'h96);
`endif

      // Randomized transfers against a register-level model
      m_hold = 8'h00; m_txfull = 1'b0; m_rxfull = 1'b0; m_rxdata = 8'h96; m_ovr = 1'b0;
      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(1, 0) == 1) begin
            m_hold = 8'($urandom);
            cpu_write(RDATA, m_hold);
            m_txfull = 1'b1;
         end
         n = $urandom_range(3, 1);
         spi_ss_n = 1'b0;
         for (int j = 0; j < n; j++) begin
            r = 8'($urandom);
            exp_miso = m_txfull ? m_hold : 8'hFF;
            m_txfull = 1'b0;
            spi_byte(r, 8, 1'b0, got, rdv);
            check("rnd_miso", got, exp_miso);
            if (!m_rxfull) begin
               m_rxdata = r;
               m_rxfull = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end
         frame_end();
         cpu_read(RSTAT, d);
         check("rnd_stat", d, {4'b0000, m_ovr, 1'b0, m_rxfull, ~m_txfull});
         if ($urandom_range(2, 0) != 0) begin
            cpu_read(RDATA, d);
            check("rnd_data", d, m_rxdata);
            m_rxfull = 1'b0;
         end
         if (m_ovr && $urandom_range(1, 0) == 1) begin
            cpu_write(RSTAT, 8'h08);
            m_ovr = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
